// File: rtl/miriscv_bus_pkg.sv
// Shared types and constants for the miriscv data-side peripheral bus.
// Holds the fabric state encoding, default window constants and the slot-index width helper.
package miriscv_bus_pkg;

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} bus_state_e;

   localparam logic [31:0] PERIPH_BASE_DEFAULT = 32'h8000_0000;
   localparam logic [31:0] SLOT_SIZE_DEFAULT   = 32'h0000_1000;

   function automatic int slot_idx_w(input int n_slots);
      return (n_slots > 1) ? $clog2(n_slots) : 1;
   endfunction

endpackage

// File: rtl/miriscv_bus_decoder.sv
// Combinational address decoder: byte address -> {slot index, mapped flag, in-slot offset}.
// Slot 0 is RAM (offset is the full address); slots 1.. are SLOT_SIZE windows above PERIPH_BASE.
module miriscv_bus_decoder
   import miriscv_bus_pkg::*;
#(
   parameter int          N_SLOTS     = 5,
   parameter int          RAM_SIZE    = 2048,
   parameter logic [31:0] PERIPH_BASE = PERIPH_BASE_DEFAULT,
   parameter logic [31:0] SLOT_SIZE   = SLOT_SIZE_DEFAULT
) (
   input  logic [31:0]                      addr,
   output logic [slot_idx_w(N_SLOTS)-1:0]   slot,
   output logic                             valid,
   output logic [31:0]                      offset
);

   localparam int          SLOT_W      = slot_idx_w(N_SLOTS);
   localparam int          SLOT_LOG2   = $clog2(SLOT_SIZE);
   localparam logic [31:0] RAM_LIMIT   = 32'(RAM_SIZE);
   localparam logic [31:0] PERIPH_SPAN = 32'(N_SLOTS - 1) * SLOT_SIZE;

   logic [31:0] rel;
   logic        in_ram;
   logic        in_periph;

   always_comb begin
      rel       = addr - PERIPH_BASE;
      in_ram    = addr < RAM_LIMIT;
      in_periph = (addr >= PERIPH_BASE) && (rel < PERIPH_SPAN);
      valid     = in_ram || in_periph;
      slot      = '0;
      offset    = addr & (SLOT_SIZE - 32'd1);
      if (in_ram) begin
         offset = addr;
      end else if (in_periph) begin
         // Peripheral slots start at index 1; slot 0 is reserved for RAM.
         slot = SLOT_W'((rel >> SLOT_LOG2) + 32'd1);
      end
   end

endmodule

// File: rtl/miriscv_periph_bus.sv
// Registered request/acknowledge fabric between the core data port and RAM plus peripherals,
// with a per-access timeout watchdog, error responses and a saturating error counter.
module miriscv_periph_bus
   import miriscv_bus_pkg::*;
#(
   parameter int          N_SLOTS     = 5,
   parameter int          RAM_SIZE    = 2048,
   parameter logic [31:0] PERIPH_BASE = PERIPH_BASE_DEFAULT,
   parameter logic [31:0] SLOT_SIZE   = SLOT_SIZE_DEFAULT,
   parameter int          TIMEOUT     = 16
) (
   input  logic                    clk_i,
   input  logic                    rst_n_i,
   input  logic                    req_i,
   input  logic                    we_i,
   input  logic [3:0]              be_i,
   input  logic [31:0]             addr_i,
   input  logic [31:0]             wdata_i,
   output logic                    gnt_o,
   output logic                    rvalid_o,
   output logic [31:0]             rdata_o,
   output logic                    err_o,
   output logic [N_SLOTS-1:0]      s_req_o,
   output logic                    s_we_o,
   output logic [3:0]              s_be_o,
   output logic [31:0]             s_addr_o,
   output logic [31:0]             s_wdata_o,
   input  logic [32*N_SLOTS-1:0]   s_rdata_i,
   input  logic [N_SLOTS-1:0]      s_ack_i,
   output logic [15:0]             err_count_o
);

   localparam int SLOT_W  = slot_idx_w(N_SLOTS);
   localparam int TIMER_W = $clog2(TIMEOUT);

   bus_state_e          state_q, state_d;
   logic [SLOT_W-1:0]   dec_slot, slot_q;
   logic                dec_valid;
   logic [31:0]         dec_offset;
   logic [N_SLOTS-1:0]  dec_onehot;
   logic [TIMER_W-1:0]  timer_q;
   logic                accept, ack_sel, timeout_hit, to_resp, resp_err;
   logic [31:0]         resp_data;

   miriscv_bus_decoder #(
      .N_SLOTS     (N_SLOTS),
      .RAM_SIZE    (RAM_SIZE),
      .PERIPH_BASE (PERIPH_BASE),
      .SLOT_SIZE   (SLOT_SIZE)
   ) u_decoder (
      .addr   (addr_i),
      .slot   (dec_slot),
      .valid  (dec_valid),
      .offset (dec_offset)
   );

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d     = state_q;
      gnt_o       = 1'b0;
      accept      = 1'b0;
      resp_err    = 1'b0;
      resp_data   = '0;
      ack_sel     = s_ack_i[slot_q];
      timeout_hit = timer_q == TIMER_W'(TIMEOUT - 1);
      dec_onehot  = '0;
      dec_onehot[dec_slot] = 1'b1;
      case (state_q)
         IDLE: begin
            gnt_o  = req_i;
            accept = req_i;
            if (req_i) begin
               state_d  = dec_valid ? ACCESS : RESP;
               resp_err = !dec_valid;
            end
         end
         ACCESS: begin
            // An ack on the terminal timeout cycle still completes the access cleanly.
            if (ack_sel) begin
               state_d   = RESP;
               resp_data = s_we_o ? 32'd0 : s_rdata_i[32*slot_q +: 32];
            end else if (timeout_hit) begin
               state_d  = RESP;
               resp_err = 1'b1;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      to_resp = (state_d == RESP) && (state_q != RESP);
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         slot_q      <= '0;
         s_req_o     <= '0;
         s_we_o      <= 1'b0;
         s_be_o      <= '0;
         s_addr_o    <= '0;
         s_wdata_o   <= '0;
         timer_q     <= '0;
         rvalid_o    <= 1'b0;
         err_o       <= 1'b0;
         rdata_o     <= '0;
         err_count_o <= '0;
      end else begin
         rvalid_o <= to_resp;
         if (to_resp) begin
            err_o   <= resp_err;
            rdata_o <= resp_data;
            if (resp_err && (err_count_o != 16'hFFFF)) err_count_o <= err_count_o + 16'd1;
         end
         if (accept) begin
            slot_q    <= dec_slot;
            s_we_o    <= we_i;
            s_be_o    <= be_i;
            s_addr_o  <= dec_offset;
            s_wdata_o <= wdata_i;
            timer_q   <= '0;
            s_req_o   <= dec_valid ? dec_onehot : '0;
         end else if (state_q == ACCESS) begin
            if (state_d != ACCESS) s_req_o <= '0;
            else                   timer_q <= timer_q + TIMER_W'(1);
         end
      end
   end

endmodule
